ct_spsram_2048x32_arb: RTL and testbench
========================================

CT_SPSRAM_2048X32_ARB -- requirements
Module: ct_spsram_2048x32_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: maximum consecutive write grants while a read waits.
REQ-002 SHALL have parameter INIT_DATA, default 32'h0: word written to every entry during a clear sweep.
REQ-003 SHALL have port forever_cpuclk, input, 1: sole clock; all flops rise-edge.
REQ-004 SHALL have port cpurst_b, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port inv_req, input, 1: request full-array clear sweep.
REQ-006 SHALL have port busy, output, 1: high while a clear sweep runs.
REQ-007 SHALL have port inv_done, output, 1: one-cycle pulse at sweep completion.
REQ-008 SHALL have ports wr_req (in, 1), wr_addr (in, 11), wr_data (in, 32), wr_bwe (in, 4, byte enables, active-high), wr_gnt (out, 1).
REQ-009 SHALL have ports rd_req (in, 1), rd_addr (in, 11), rd_gnt (out, 1), rd_vld (out, 1), rd_data (out, 32).
REQ-010 SHALL have SRAM-side ports sram_a (out, 11), sram_cen (out, 1, active-low), sram_gwen (out, 1, active-low write), sram_wen (out, 32, active-low per bit), sram_d (out, 32), sram_q (in, 32).

Function
REQ-011 SHALL implement FSM states INIT (clear sweep) and RUN (arbitration).
REQ-012 SHALL hold an 11-bit sweep counter. In INIT, each cycle: sram_cen=0, sram_gwen=0, sram_wen=32'h0, sram_a=counter, sram_d=INIT_DATA; counter then increments.
REQ-013 SHALL, on counter==2047 in INIT, write the final entry, go to RUN, clear the counter to 0, and pulse inv_done in the following cycle.
REQ-014 SHALL, in INIT, drive busy=1 and wr_gnt=rd_gnt=0 regardless of requests.
REQ-015 SHALL, in RUN, go to INIT with the counter at 0 when inv_req=1. That cycle still arbitrates normally.
REQ-016 SHALL ignore inv_req while in INIT; the sweep neither restarts nor extends.
REQ-017 SHALL, in RUN, compute grants combinationally in the same cycle. A transfer occurs when req and gnt are both high. Requesters hold req/addr/data stable until granted.
REQ-018 SHALL give write priority over read, except when the starvation count equals STARVE_LIMIT and rd_req=1; then read is granted.
REQ-019 SHALL increment a starvation count on each write grant with rd_req=1, saturating at STARVE_LIMIT. The count clears on any read grant or any cycle with rd_req=0.
REQ-020 SHALL, for a write grant, drive sram_cen=0, sram_gwen=0, sram_a=wr_addr, sram_d=wr_data, and sram_wen[8k+7:8k]={8{~wr_bwe[k]}}.
REQ-021 SHALL, for a read grant, drive sram_cen=0, sram_gwen=1, sram_a=rd_addr, and sram_wen=all ones.
REQ-022 SHALL, in idle cycles, drive sram_cen=1, sram_gwen=1, sram_wen=all ones, and sram_a/sram_d=0.
REQ-023 SHALL register rd_vld as rd_gnt delayed one cycle, and drive rd_data=sram_q combinationally; rd_data is valid only while rd_vld=1.
REQ-024 SHALL allow a write with wr_bwe=4'h0. It is granted and consumes a cycle but modifies no bit.
REQ-025 SHALL never grant both requesters in one cycle.
REQ-026 SHALL give a read issued the cycle after a same-address write the newly written data (SRAM write-then-read ordering).

Reset
REQ-027 SHALL, on cpurst_b=0, asynchronously set state=INIT, counter=0, starvation count=0, rd_vld=0, inv_done=0.
REQ-028 SHALL, while cpurst_b=0, drive busy=1, wr_gnt=0, rd_gnt=0, sram_cen=1, sram_gwen=1, sram_wen=all ones.
REQ-029 SHALL start a full 2048-cycle sweep automatically on reset release.
REQ-030 SHALL, on reset asserted mid-sweep or mid-access, abort the operation. The sweep restarts at entry 0 after release, and no rd_vld is produced for an aborted read.

Verification
REQ-031 SHALL cover post-reset sweep: release cpurst_b, then busy=1 for 2048 cycles with addresses 0..2047 in order, inv_done pulses once, and a read of 0x7FF returns INIT_DATA.
REQ-032 SHALL cover byte write: write 0x123 data 32'hAABBCCDD bwe 4'b0101, then read 0x123 -> rd_vld next cycle with rd_data 32'h00BB00DD.
REQ-033 SHALL cover starvation: hold wr_req and rd_req continuously -> grant order W,W,W,R,W,W,W,R (STARVE_LIMIT=3).
REQ-034 SHALL cover invalidate during traffic: inv_req in RUN with a write granted -> write completes, then 2048-cycle sweep with no grants, then inv_done.
REQ-035 SHALL cover mid-sweep reset: assert cpurst_b low at sweep entry 1000 -> all SRAM controls are inactive; after release, the sweep restarts at address 0.
REQ-036 SHALL cover write-bwe-zero corner: wr_bwe=4'h0 -> wr_gnt=1, sram_wen all ones with sram_cen=0, and a later read shows the data unchanged.

Source files
------------

// File: rtl/ct_spsram_2048x32_arb.sv
// Purpose : arbitrates one write and one read requester onto a 2048x32 single-port SRAM, with a full-array clear sweep.
// Latency : grants are combinational in the request cycle; rd_vld/rd_data follow one cycle after rd_gnt.
// Backpressure: a requester holds req/addr/data until its grant; no grants while a sweep is running or in reset.
//
// Ports:
//   forever_cpuclk, cpurst_b          - clock (rising edge) and async active-low reset
//   inv_req / busy / inv_done         - start a clear sweep, sweep running, one-cycle completion pulse
//   wr_req/wr_addr/wr_data/wr_bwe/wr_gnt - write requester (per-byte enables, active-high)
//   rd_req/rd_addr/rd_gnt/rd_vld/rd_data - read requester; rd_data is sram_q, valid while rd_vld
//   sram_a/sram_cen/sram_gwen/sram_wen/sram_d/sram_q - SRAM macro side (enables active-low)
module ct_spsram_2048x32_arb #(
    parameter int          STARVE_LIMIT = 3,
    parameter logic [31:0] INIT_DATA    = 32'h0
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        inv_req,
    output logic        busy,
    output logic        inv_done,
    input  logic        wr_req,
    input  logic [10:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_bwe,
    output logic        wr_gnt,
    input  logic        rd_req,
    input  logic [10:0] rd_addr,
    output logic        rd_gnt,
    output logic        rd_vld,
    output logic [31:0] rd_data,
    output logic [10:0] sram_a,
    output logic        sram_cen,
    output logic        sram_gwen,
    output logic [31:0] sram_wen,
    output logic [31:0] sram_d,
    input  logic [31:0] sram_q
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [10:0]    cnt;
    logic [SW-1:0]  starve;
    logic           starved;

    // A waiting read wins only once the write side has used up its allowance.
    assign starved = rd_req && (starve == LIM);
    assign rd_data = sram_q;

    always_comb begin
        wr_gnt    = 1'b0;
        rd_gnt    = 1'b0;
        busy      = (state == INIT) || !cpurst_b;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        // Reset is folded in combinationally so the macro sees no access while held in reset.
        if (cpurst_b) begin
            if (state == INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt;
                sram_d    = INIT_DATA;
            end else begin
                wr_gnt = wr_req && !starved;
                rd_gnt = rd_req && !wr_gnt;
                if (wr_gnt) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_a    = wr_addr;
                    sram_d    = wr_data;
                    for (int k = 0; k < 4; k++) begin
                        sram_wen[8*k +: 8] = {8{~wr_bwe[k]}};
                    end
                end else if (rd_gnt) begin
                    sram_cen = 1'b0;
                    sram_a   = rd_addr;
                end
            end
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state    <= INIT;
            cnt      <= '0;
            starve   <= '0;
            rd_vld   <= 1'b0;
            inv_done <= 1'b0;
        end else begin
            rd_vld   <= rd_gnt;
            inv_done <= 1'b0;
            case (state)
                INIT: begin
                    // inv_req is deliberately not looked at here: a sweep never restarts or extends.
                    starve <= '0;
                    if (cnt == 11'h7FF) begin
                        state    <= RUN;
                        cnt      <= '0;
                        inv_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                RUN: begin
                    if (inv_req) begin
                        state <= INIT;
                        cnt   <= '0;
                    end
                    if (rd_gnt || !rd_req) begin
                        starve <= '0;
                    end else if (wr_gnt && starve != LIM) begin
                        starve <= starve + SW'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_2048x32_arb.sv
module tb_ct_spsram_2048x32_arb;

    localparam logic [31:0] INIT_DATA = 32'h0;

    logic        clk;
    logic        cpurst_b;
    logic        inv_req;
    logic        busy, inv_done;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_bwe;
    logic        wr_gnt;
    logic        rd_req;
    logic [10:0] rd_addr;
    logic        rd_gnt, rd_vld;
    logic [31:0] rd_data;
    logic [10:0] sram_a;
    logic        sram_cen, sram_gwen;
    logic [31:0] sram_wen, sram_d, sram_q;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram_mem  [0:2047];
    logic [31:0] model_mem [0:2047];
    logic [31:0] sb [$];

    ct_spsram_2048x32_arb #(.STARVE_LIMIT(3), .INIT_DATA(INIT_DATA)) dut (
        .forever_cpuclk(clk), .cpurst_b(cpurst_b), .inv_req(inv_req),
        .busy(busy), .inv_done(inv_done),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bwe(wr_bwe), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_vld(rd_vld), .rd_data(rd_data),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port SRAM: bit-masked write, registered read.
    always @(posedge clk) begin
        if (sram_cen === 1'b0) begin
            if (sram_gwen === 1'b0)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    // Read-data scoreboard: every rd_vld must match the oldest outstanding expected word.
    always @(negedge clk) begin
        #2;
        if (rd_vld === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rd_vld_unexpected: rd_vld=1 rd_data=%h, required no read outstanding", rd_data);
            end else begin
                logic [31:0] exp;
                exp = sb.pop_front();
                if (rd_data !== exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h, required %h", rd_data, exp);
                end
            end
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        inv_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; wr_bwe = '0; rd_addr = '0;
    endtask

    // Caller has just entered sweep cycle 0 (at the negedge). Stops early at stop_at if >= 0.
    task automatic run_sweep(input string tag, input int stop_at);
        for (int j = 0; j < 2048; j++) model_mem[j] = INIT_DATA;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) step();
            #1;
            checks++;
            if ({busy, wr_gnt, rd_gnt, inv_done, sram_cen, sram_gwen} !== 6'b100000 ||
                sram_wen !== 32'h0 || sram_a !== 11'(i) || sram_d !== INIT_DATA) begin
                errors++;
                $display("FAIL sweep_%s i=%0d: busy=%b wg=%b rg=%b done=%b cen=%b gwen=%b wen=%h a=%h d=%h, required busy=1 gnts=0 done=0 cen=0 gwen=0 wen=0 a=%h d=%h",
                         tag, i, busy, wr_gnt, rd_gnt, inv_done, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, 11'(i), INIT_DATA);
            end
            if (i == stop_at) return;
        end
        step(); clear_reqs(); #1;
        checks++;
        if (inv_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_%s_done: inv_done=%b busy=%b, required 1 0", tag, inv_done, busy);
        end
        step(); #1;
        checks++;
        if (inv_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_%s_done_pulse: inv_done=%b, required 0", tag, inv_done);
        end
    endtask

    task automatic test_reset();
        cpurst_b = 1'b0;
        clear_reqs();
        wr_req = 1'b1; rd_req = 1'b1; inv_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            checks++;
            if (busy !== 1'b1 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt: busy=%b wg=%b rg=%b, required 1 0 0", busy, wr_gnt, rd_gnt);
            end
            checks++;
            if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL reset_sram: cen=%b gwen=%b wen=%h, required 1 1 ffffffff", sram_cen, sram_gwen, sram_wen);
            end
            checks++;
            if (rd_vld !== 1'b0 || inv_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_regs: rd_vld=%b inv_done=%b, required 0 0", rd_vld, inv_done);
            end
        end
    endtask

    task automatic test_post_reset_sweep();
        step(); cpurst_b = 1'b1;       // requests stay high: the sweep must ignore them
        run_sweep("post_reset", -1);
        step(); rd_req = 1'b1; rd_addr = 11'h7FF; #1;
        checks++;
        if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0 || sram_cen !== 1'b0 || sram_gwen !== 1'b1 ||
            sram_a !== 11'h7FF || sram_wen !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL read_7ff_issue: rg=%b wg=%b cen=%b gwen=%b a=%h wen=%h, required 1 0 0 1 7ff ffffffff",
                     rd_gnt, wr_gnt, sram_cen, sram_gwen, sram_a, sram_wen);
        end
        sb.push_back(INIT_DATA);
        step(); clear_reqs(); #1;
        checks++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 32'hFFFF_FFFF || sram_a !== 11'h0 || sram_d !== 32'h0) begin
            errors++;
            $display("FAIL idle_outputs: cen=%b gwen=%b wen=%h a=%h d=%h, required 1 1 ffffffff 0 0",
                     sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
        end
    endtask

    task automatic test_byte_write();
        step(); wr_req = 1'b1; wr_addr = 11'h123; wr_data = 32'hAABBCCDD; wr_bwe = 4'b0101; #1;
        checks++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
            sram_a !== 11'h123 || sram_d !== 32'hAABBCCDD || sram_wen !== 32'hFF00FF00) begin
            errors++;
            $display("FAIL byte_write: wg=%b rg=%b cen=%b gwen=%b a=%h d=%h wen=%h, required 1 0 0 0 123 aabbccdd ff00ff00",
                     wr_gnt, rd_gnt, sram_cen, sram_gwen, sram_a, sram_d, sram_wen);
        end
        model_mem[11'h123] = merge(model_mem[11'h123], 32'hAABBCCDD, 4'b0101);
        // Read the same address in the very next cycle.
        step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'h123; #1;
        checks++;
        if (rd_gnt !== 1'b1 || sram_gwen !== 1'b1 || sram_a !== 11'h123) begin
            errors++;
            $display("FAIL byte_read_issue: rg=%b gwen=%b a=%h, required 1 1 123", rd_gnt, sram_gwen, sram_a);
        end
        sb.push_back(32'h00BB00DD);
        step(); clear_reqs(); #1;
        checks++;
        if (rd_vld !== 1'b1) begin
            errors++;
            $display("FAIL byte_read_vld: rd_vld=%b, required 1", rd_vld);
        end
    endtask

    task automatic test_starvation();
        logic [7:0]  rd_pat;
        logic [31:0] wd;
        int w, r;
        rd_pat = 8'b1000_1000;      // W,W,W,R,W,W,W,R
        wd = $urandom; w = 0; r = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            wr_req = 1'b1; wr_addr = 11'h200 + 11'(w); wr_data = wd; wr_bwe = 4'hF;
            rd_req = 1'b1; rd_addr = (r == 0) ? 11'h123 : 11'h200;
            #1;
            checks++;
            if (wr_gnt !== ~rd_pat[i] || rd_gnt !== rd_pat[i]) begin
                errors++;
                $display("FAIL starve_order cycle=%0d: wg=%b rg=%b, required %b %b", i, wr_gnt, rd_gnt, ~rd_pat[i], rd_pat[i]);
            end
            if (!rd_pat[i]) begin
                model_mem[wr_addr] = wd;
                w++; wd = $urandom;
            end else begin
                sb.push_back(model_mem[rd_addr]);
                r++;
            end
        end
        step(); clear_reqs();
    endtask

    task automatic test_bwe_zero();
        step(); wr_req = 1'b1; wr_addr = 11'h200; wr_data = ~model_mem[11'h200]; wr_bwe = 4'h0; #1;
        checks++;
        if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || sram_cen !== 1'b0 || sram_wen !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL bwe_zero: wg=%b rg=%b cen=%b wen=%h, required 1 0 0 ffffffff", wr_gnt, rd_gnt, sram_cen, sram_wen);
        end
        step(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'h200; #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL bwe_zero_read: rg=%b, required 1", rd_gnt);
        end
        sb.push_back(model_mem[11'h200]);
        step(); clear_reqs();
    endtask

    task automatic test_inv_during_traffic();
        step(); inv_req = 1'b1; wr_req = 1'b1; wr_addr = 11'h300; wr_data = 32'h5A5A_1234; wr_bwe = 4'hF; #1;
        checks++;
        if (wr_gnt !== 1'b1 || busy !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== 11'h300) begin
            errors++;
            $display("FAIL inv_cycle_write: wg=%b busy=%b gwen=%b a=%h, required 1 0 0 300", wr_gnt, busy, sram_gwen, sram_a);
        end
        step(); wr_addr = 11'h301; rd_req = 1'b1; rd_addr = 11'h300;   // inv_req stays high: ignored in sweep
        run_sweep("inv", -1);
        step(); rd_req = 1'b1; rd_addr = 11'h300; #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL inv_read_back: rg=%b, required 1", rd_gnt);
        end
        sb.push_back(model_mem[11'h300]);
        step(); clear_reqs();
    endtask

    task automatic test_mid_reset();
        // Reset during a granted read: no rd_vld may follow.
        step(); rd_req = 1'b1; rd_addr = 11'h123; #1;
        checks++;
        if (rd_gnt !== 1'b1) begin
            errors++;
            $display("FAIL abort_read_gnt: rg=%b, required 1", rd_gnt);
        end
        #2; cpurst_b = 1'b0; wr_req = 1'b1; #1;
        checks++;
        if (rd_gnt !== 1'b0 || wr_gnt !== 1'b0 || sram_cen !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_read_ctl: rg=%b wg=%b cen=%b busy=%b, required 0 0 1 1", rd_gnt, wr_gnt, sram_cen, busy);
        end
        step(); #1;
        checks++;
        if (rd_vld !== 1'b0) begin
            errors++;
            $display("FAIL abort_read_vld: rd_vld=%b, required 0", rd_vld);
        end
        step(); cpurst_b = 1'b1;
        run_sweep("after_abort", -1);
        // Start a sweep from idle, then reset at entry 1000.
        step(); inv_req = 1'b1; #1;
        checks++;
        if (busy !== 1'b0 || sram_cen !== 1'b1) begin
            errors++;
            $display("FAIL inv_idle_cycle: busy=%b cen=%b, required 0 1", busy, sram_cen);
        end
        step(); inv_req = 1'b0; wr_req = 1'b1;
        run_sweep("partial", 1000);
        #2; cpurst_b = 1'b0; #1;
        checks++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 32'hFFFF_FFFF || wr_gnt !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_sweep_reset: cen=%b gwen=%b wen=%h wg=%b busy=%b, required 1 1 ffffffff 0 1",
                     sram_cen, sram_gwen, sram_wen, wr_gnt, busy);
        end
        step(); step(); cpurst_b = 1'b1;
        run_sweep("restart", -1);
    endtask

    initial begin
        clear_reqs();
        cpurst_b = 1'b0;
        test_reset();
        test_post_reset_sweep();
        test_byte_write();
        test_starvation();
        test_bwe_zero();
        test_inv_during_traffic();
        test_mid_reset();
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reads_outstanding: %0d reads never returned, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
